// File: rtl/pipe_exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
// Latency: WIDTH iterations after the accept edge, done in cycle WIDTH+1 (divide-by-zero fast path: cycle 1).
// Backpressure: stall_req holds the pipeline while a long op is pending; start while busy is ignored.
module pipe_exe_muldiv #(
    parameter int WIDTH   = 32,
    parameter int DZ_FAST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] upper, lower, opnd, a_q;
    logic             neg_q, rneg_q, dz_q;

    // Operation decode and operand magnitudes for the signed variants.
    logic             is_mul, is_div, is_signed, long_op, b_zero, last;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign is_mul    = (op == 3'd0) || (op == 3'd1);
    assign is_div    = (op == 3'd2) || (op == 3'd3);
    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign long_op   = is_mul || is_div;
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;
    assign b_zero    = (b == '0);
    assign last      = (cnt == CW'(WIDTH - 1));

    // Shift-add multiply step: {upper,lower} holds partial product and remaining multiplier bits.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_upper_n, mul_lower_n;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign mul_sum     = {1'b0, upper} + {1'b0, (lower[0] ? opnd : '0)};
    assign mul_upper_n = mul_sum[WIDTH:1];
    assign mul_lower_n = {mul_sum[0], lower[WIDTH-1:1]};
    assign prod        = {mul_upper_n, mul_lower_n};
    assign prod_s      = neg_q ? -prod : prod;

    // Restoring divide step: upper is the partial remainder, lower shifts dividend out / quotient in.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_upper_n, div_lower_n, quo_s, rem_s;

    assign div_shift   = {upper, lower[WIDTH-1]};
    assign div_ge      = (div_shift >= {1'b0, opnd});
    // When the trial succeeds the difference is below the divisor, so modulo-WIDTH subtraction is exact.
    assign div_upper_n = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
    assign div_lower_n = {lower[WIDTH-2:0], div_ge};
    assign quo_s       = neg_q  ? -div_lower_n : div_lower_n;
    assign rem_s       = rneg_q ? -div_upper_n : div_upper_n;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs; flush overrides everything including a new start.
    always_comb begin
        state_nxt   = state;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        div_by_zero = (state == S_DONE) && dz_q;
        stall_req   = start && long_op && (state != S_DONE);
        case (state)
            S_IDLE: begin
                if (start && is_mul)
                    state_nxt = S_MUL;
                else if (start && is_div)
                    state_nxt = (b_zero && (DZ_FAST != 0)) ? S_DONE : S_DIV;
            end
            S_MUL:   if (last) state_nxt = S_DONE;
            S_DIV:   if (last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Datapath: latch operands on accept, iterate, and commit hi/lo only on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            upper  <= '0;
            lower  <= '0;
            opnd   <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        if (is_mul) begin
                            upper <= '0;
                            lower <= b_abs;
                            opnd  <= a_abs;
                            neg_q <= a_neg ^ b_neg;
                            dz_q  <= 1'b0;
                        end else if (is_div) begin
                            upper  <= '0;
                            lower  <= a_abs;
                            opnd   <= b_abs;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                            a_q    <= a;
                            dz_q   <= b_zero;
                            if (b_zero && (DZ_FAST != 0)) begin
                                hi <= a;
                                lo <= '1;
                            end
                        end else if (op == 3'd4) begin
                            hi <= a;
                        end else if (op == 3'd5) begin
                            lo <= a;
                        end
                    end
                end
                S_MUL: begin
                    upper <= mul_upper_n;
                    lower <= mul_lower_n;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    upper <= div_upper_n;
                    lower <= div_lower_n;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // A zero divisor yields all-ones quotient and the dividend as remainder.
                        hi <= dz_q ? a_q : rem_s;
                        lo <= dz_q ? '1  : quo_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Testbench for pipe_exe_muldiv: directed vectors, expected results queued at issue,
// a monitor pops and compares whenever done pulses.
module tb_pipe_exe_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, stall_req, done, div_by_zero;
    logic [W-1:0] hi, lo;

    pipe_exe_muldiv #(.WIDTH(W), .DZ_FAST(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall_req(stall_req), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one long op, hold start until done, scramble a/b after the accept edge.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                         input int lat);
        logic [W-1:0] old_hi, old_lo;
        int  stalls;
        bit  seen, held;
        old_hi = hi;
        old_lo = lo;
        op = o; a = ia; b = ib; start = 1'b1;
        sbq.push_back('{ehi, elo, edz, cyc + lat});
        stalls = 0; seen = 0; held = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done) seen = 1;
            else if (hi !== old_hi || lo !== old_lo) held = 0;
            @(posedge clk); #1;
            if (i == 0) begin
                a = $urandom;
                b = $urandom;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("hilo_held_until_done", 64'(held), 64'd1);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int dn;
        logic [W-1:0] kh, kl;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33);
        // MULT -3 * 5 = -15
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
        // DIV -7 / 2 = -3 rem -1
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        // DIVU 100 / 0, fast path
        do_op(3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1);
        // DIV overflow 0x80000000 / -1
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
        // DIVU 100 / 7 = 14 rem 2
        do_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        // DIV 7 / -2 = -3 rem 1 (remainder follows dividend)
        do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
        // MULT (-2^31)^2 = 2^62
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
        // DIV -5 / 0, signed divide by zero
        do_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1);

        // MTHI then MTLO back-to-back: no stall, no done.
        op = 3'd4; a = 32'h1234; start = 1'b1;
        @(negedge clk);
        chk("mthi_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        op = 3'd5; a = 32'h5678;
        @(negedge clk);
        chk("mtlo_stall", 64'(stall_req), 64'd0);
        chk("mtlo_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mtlo_lo", 64'(lo), 64'h5678);

        // Undefined op code behaves as a no-op.
        op = 3'd6; a = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        chk("nop_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("nop_busy", 64'(busy), 64'd0);
        chk("nop_hi", 64'(hi), 64'h1234);
        chk("nop_lo", 64'(lo), 64'h5678);

        // Flush a running MULT in cycle 10.
        kh = hi; kl = lo;
        op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_idle", 64'(busy), 64'd0);
        chk("flush_hi_kept", 64'(hi), 64'(kh));
        chk("flush_lo_kept", 64'(lo), 64'(kl));
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        @(posedge clk); #1;

        // Async reset in cycle 5 of a DIV.
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("div_busy_before_rst", 64'(busy), 64'd1);
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_dz", 64'(div_by_zero), 64'd0);
        chk("arst_stall", 64'(stall_req), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Recovery after reset: MULT -1 * -1 = 1
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
